// File: rtl/sm_rr_scheduler.sv
// sm_rr_scheduler
// Shares one sequential multiplier between NUM_REQ requesters. One operand pair
// is accepted at a time over a valid/ready handshake. Requesters are granted in
// round-robin order. The accepted pair is launched into the multiplier with a
// one-cycle start pulse. After MUL_LAT cycles the product is captured and
// returned, tagged with the index of the requester that sent it.
//
// Transaction flow: IDLE -> START -> WAIT -> RESP -> IDLE.
// Exactly one transaction is in flight at any time.

module sm_rr_scheduler #(
  parameter int NUM_REQ = 4,   // number of requesters, 2..8
  parameter int W       = 4,   // operand width; the product is 2*W bits
  parameter int MUL_LAT = 10   // cycles from the start pulse to a valid product, >= 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,          // synchronous, active-low
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [W*NUM_REQ-1:0]       i_req_mr,
  input  logic [W*NUM_REQ-1:0]       i_req_md,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_resp_valid,
  output logic [$clog2(NUM_REQ)-1:0] o_resp_id,
  output logic [2*W-1:0]             o_resp_product,
  input  logic                       i_resp_ready,
  output logic                       o_mul_start,
  output logic [W-1:0]               o_mul_mr,
  output logic [W-1:0]               o_mul_md,
  input  logic [2*W-1:0]             i_mul_product
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  // The WAIT countdown starts at MUL_LAT-1. The product is therefore sampled
  // at the end of the MUL_LAT-th cycle after the start pulse.
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(MUL_LAT - 1);
  // NUM_REQ in the one-bit-wider width used by the wrap-around scan.
  localparam logic [ID_W:0]    NUM_REQ_EXT = (ID_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [ID_W-1:0]    r_ptr;           // highest-priority requester for the next grant
  logic [ID_W-1:0]    r_id;            // owner of the in-flight / returned transaction
  logic [W-1:0]       r_mul_mr;
  logic [W-1:0]       r_mul_md;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*W-1:0]     r_resp_product;

  logic               w_grant_found;
  logic [ID_W-1:0]    w_grant_id;
  logic [ID_W:0]      w_scan_idx;
  logic [NUM_REQ-1:0] w_grant_onehot;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic [W-1:0]       w_sel_mr;
  logic [W-1:0]       w_sel_md;
  logic               w_xfer;
  logic               w_cnt_zero;

  // Round-robin search: the first valid requester at or above the pointer, with wrap-around.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    w_scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_scan_idx >= NUM_REQ_EXT) begin
        w_scan_idx = w_scan_idx - NUM_REQ_EXT;
      end
      if (!w_grant_found && i_req_valid[w_scan_idx[ID_W-1:0]]) begin
        w_grant_found = 1'b1;
        w_grant_id    = w_scan_idx[ID_W-1:0];
      end
    end
  end

  // Operand slice of the granted requester.
  always_comb begin
    w_sel_mr = '0;
    w_sel_md = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant_id == ID_W'(k)) begin
        w_sel_mr = i_req_mr[W*k +: W];
        w_sel_md = i_req_md[W*k +: W];
      end
    end
  end

  assign w_grant_onehot = NUM_REQ'(w_grant_found) << w_grant_id;

  // A grant is offered only while idle. While any other transaction is open,
  // every requester sees ready low.
  assign o_req_ready = (r_state == ST_IDLE) ? w_grant_onehot : '0;
  assign w_xfer      = |(i_req_valid & o_req_ready);

  // The pointer moves just past the winner, wrapping from NUM_REQ-1 to 0.
  assign w_ptr_nxt   = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);

  assign w_cnt_zero  = (r_cnt == '0);

  // State register; reset from any state drops the in-flight transaction.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (!i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and the state-decoded strobes (start pulse, response valid).
  always_comb begin
    w_state_nxt  = r_state;
    o_mul_start  = 1'b0;
    o_resp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        o_mul_start = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath registers: accept capture, latency countdown and product capture.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_ptr          <= '0;
      r_id           <= '0;
      r_mul_mr       <= '0;
      r_mul_md       <= '0;
      r_cnt          <= '0;
      r_resp_product <= '0;
    end else begin
      // The operands stay in these registers until the next accept. This holds
      // the multiplier inputs stable for the whole transaction.
      if (w_xfer) begin
        r_ptr    <= w_ptr_nxt;
        r_id     <= w_grant_id;
        r_mul_mr <= w_sel_mr;
        r_mul_md <= w_sel_md;
      end
      case (r_state)
        ST_START: begin
          r_cnt <= CNT_LOAD;
        end
        ST_WAIT: begin
          if (w_cnt_zero) begin
            r_resp_product <= i_mul_product;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_resp_id      = r_id;
  assign o_resp_product = r_resp_product;
  assign o_mul_mr       = r_mul_mr;
  assign o_mul_md       = r_mul_md;

endmodule

// File: tb/tb_sm_rr_scheduler.sv
// Bench for sm_rr_scheduler.
// The reference model tracks one transaction by its accept cycle. From that
// cycle it derives when the start pulse and the response must appear.
// A multiplier model returns the true product only from MUL_LAT cycles after
// the start pulse. Before that it returns a value that is guaranteed wrong.
// Directed scenarios pin the model with literal values. A randomized phase
// then compares every cycle against the model.

module tb_sm_rr_scheduler;

  localparam int N    = 4;
  localparam int W    = 4;
  localparam int L    = 10;
  localparam int ID_W = $clog2(N);

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_valid;
  logic [W*N-1:0]      req_mr;
  logic [W*N-1:0]      req_md;
  logic [N-1:0]        req_ready;
  logic                resp_valid;
  logic [ID_W-1:0]     resp_id;
  logic [2*W-1:0]      resp_product;
  logic                resp_ready;
  logic                mul_start;
  logic [W-1:0]        mul_mr;
  logic [W-1:0]        mul_md;
  logic [2*W-1:0]      mul_product;

  // Stimulus staged by the scenario code and applied at the next falling edge.
  logic                s_rst;
  logic [N-1:0]        s_req_valid;
  logic [W*N-1:0]      s_req_mr;
  logic [W*N-1:0]      s_req_md;
  logic                s_resp_ready;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model state.
  bit              m_busy;
  int              m_acc;
  int              m_id;
  logic [W-1:0]    m_mr;
  logic [W-1:0]    m_md;
  logic [2*W-1:0]  m_prod;
  int              m_ptr;
  int              acc_log[$];

  // Multiplier model state.
  bit              mm_started;
  int              mm_start;
  logic [W-1:0]    mm_mr;
  logic [W-1:0]    mm_md;

  // Responses actually handed over by the DUT.
  int              resp_id_log[$];
  int              resp_prod_log[$];

  always #5 clk = ~clk;

  sm_rr_scheduler #(.NUM_REQ(N), .W(W), .MUL_LAT(L)) u_dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .i_req_mr       (req_mr),
    .i_req_md       (req_md),
    .o_req_ready    (req_ready),
    .o_resp_valid   (resp_valid),
    .o_resp_id      (resp_id),
    .o_resp_product (resp_product),
    .i_resp_ready   (resp_ready),
    .o_mul_start    (mul_start),
    .o_mul_mr       (mul_mr),
    .o_mul_md       (mul_md),
    .i_mul_product  (mul_product)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic int get_id(input int i);
    return (i < resp_id_log.size()) ? resp_id_log[i] : -1;
  endfunction

  function automatic int get_prod(input int i);
    return (i < resp_prod_log.size()) ? resp_prod_log[i] : -1;
  endfunction

  function automatic int get_acc(input int i);
    return (i < acc_log.size()) ? acc_log[i] : -1;
  endfunction

  task automatic clear_logs();
    resp_id_log.delete();
    resp_prod_log.delete();
    acc_log.delete();
  endtask

  task automatic set_ops(input int id, input int mr, input int md);
    s_req_mr[W*id +: W] = W'(mr);
    s_req_md[W*id +: W] = W'(md);
  endtask

  // One clock cycle: apply inputs, compare all outputs with the model, then
  // advance the model by the cycle's inputs.
  task automatic step();
    logic [2*W-1:0] good;
    logic [N-1:0]   e_ready;
    bit             e_start;
    bit             e_resp;
    bit             busy0;
    int             g;
    @(negedge clk);
    rst        = s_rst;
    req_valid  = s_req_valid;
    req_mr     = s_req_mr;
    req_md     = s_req_md;
    resp_ready = s_resp_ready;
    good = (2*W)'(mm_mr) * (2*W)'(mm_md);
    if (mm_started && cyc >= mm_start + L) mul_product = good;
    else mul_product = good ^ (2*W)'($urandom_range(1, 255));
    #1;
    g       = rr_pick(req_valid, m_ptr);
    e_ready = (!m_busy && g >= 0) ? (N'(1) << g) : '0;
    e_start = m_busy && (cyc == m_acc + 1);
    e_resp  = m_busy && (cyc >= m_acc + L + 2);
    check("req_ready",    req_ready,    e_ready);
    check("mul_start",    mul_start,    e_start);
    check("resp_valid",   resp_valid,   e_resp);
    check("resp_id",      resp_id,      m_id);
    check("resp_product", resp_product, m_prod);
    check("mul_mr",       mul_mr,       m_mr);
    check("mul_md",       mul_md,       m_md);
    if (rst && resp_valid && resp_ready) begin
      resp_id_log.push_back(int'(resp_id));
      resp_prod_log.push_back(int'(resp_product));
    end
    if (!rst) begin
      mm_started = 1'b0;
    end else if (mul_start) begin
      mm_started = 1'b1;
      mm_start   = cyc;
      mm_mr      = mul_mr;
      mm_md      = mul_md;
    end
    busy0 = m_busy;
    if (!rst) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      m_id   = 0;
      m_mr   = '0;
      m_md   = '0;
      m_prod = '0;
    end else begin
      if (busy0 && cyc == m_acc + L + 1) m_prod = (2*W)'(m_mr) * (2*W)'(m_md);
      if (e_resp && resp_ready) m_busy = 1'b0;
      if (!busy0 && g >= 0) begin
        m_busy = 1'b1;
        m_acc  = cyc;
        m_id   = g;
        m_mr   = req_mr[W*g +: W];
        m_md   = req_md[W*g +: W];
        m_ptr  = (g + 1) % N;
        acc_log.push_back(g);
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    s_rst = 1'b0;
    step();
    s_rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; req_mr = '0; req_md = '0;
    resp_ready = 1'b0; mul_product = '0;
    s_rst = 1'b0; s_req_valid = '0; s_req_mr = '0; s_req_md = '0; s_resp_ready = 1'b1;
    m_busy = 1'b0; m_acc = 0; m_id = 0; m_mr = '0; m_md = '0; m_prod = '0; m_ptr = 0;
    mm_started = 1'b0; mm_start = 0; mm_mr = '0; mm_md = '0;

    // Reset state.
    run(2);
    s_rst = 1'b1;
    step();
    check("rst_req_ready",    req_ready,    0);
    check("rst_resp_valid",   resp_valid,   0);
    check("rst_resp_id",      resp_id,      0);
    check("rst_resp_product", resp_product, 0);
    check("rst_mul_start",    mul_start,    0);
    check("rst_mul_mr",       mul_mr,       0);
    check("rst_mul_md",       mul_md,       0);

    // Single request, 13*11, with exact latency.
    set_ops(0, 13, 11);
    s_req_valid = 4'b0001;
    step();
    check("t1_grant", req_ready, 4'b0001);
    s_req_valid = '0;
    step();
    check("t1_start", mul_start, 1);
    run(L);
    check("t1_not_early", resp_valid, 0);
    step();
    check("t1_resp_valid",   resp_valid,   1);
    check("t1_resp_id",      resp_id,      0);
    check("t1_resp_product", resp_product, 143);
    check("t1_model_pin",    m_prod,       143);
    step();
    check("t1_one_cycle", resp_valid, 0);

    // All requesters active: rotation 0,1,2,3,0 with correct products.
    do_reset();
    set_ops(0, 2, 3); set_ops(1, 5, 7); set_ops(2, 9, 4); set_ops(3, 15, 15);
    clear_logs();
    s_req_valid = 4'b1111;
    run(4 * (L + 3) + 2);
    check("t2_acc0", get_acc(0), 0);
    check("t2_acc1", get_acc(1), 1);
    check("t2_acc2", get_acc(2), 2);
    check("t2_acc3", get_acc(3), 3);
    check("t2_acc4", get_acc(4), 0);
    check("t2_id0",  get_id(0), 0);
    check("t2_id1",  get_id(1), 1);
    check("t2_id2",  get_id(2), 2);
    check("t2_id3",  get_id(3), 3);
    check("t2_p0",   get_prod(0), 6);
    check("t2_p1",   get_prod(1), 35);
    check("t2_p2",   get_prod(2), 36);
    check("t2_p3",   get_prod(3), 225);

    // The pointer sits at 3 after a grant to 2; requests 0 and 2 are then served 0 first.
    do_reset();
    set_ops(2, 3, 3);
    s_req_valid = 4'b0100;
    step();
    s_req_valid = '0;
    run(L + 2);
    clear_logs();
    set_ops(0, 6, 6);
    s_req_valid = 4'b0101;
    run(2 * (L + 3));
    check("t3_id0", get_id(0), 0);
    check("t3_id1", get_id(1), 2);
    check("t3_p0",  get_prod(0), 36);
    check("t3_p1",  get_prod(1), 9);

    // Backpressure: 20 stalled cycles in RESP while every requester is valid.
    clear_logs();
    set_ops(1, 7, 9);
    s_resp_ready = 1'b0;
    s_req_valid  = 4'b0010;
    step();
    s_req_valid = '0;
    run(L + 1);
    s_req_valid = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      step();
      check("t4_hold_valid",   resp_valid,   1);
      check("t4_hold_id",      resp_id,      1);
      check("t4_hold_product", resp_product, 63);
      check("t4_hold_ready",   req_ready,    0);
    end
    s_req_valid  = '0;
    s_resp_ready = 1'b1;
    step();
    step();
    check("t4_released",   resp_valid, 0);
    check("t4_count",      resp_id_log.size(), 1);
    check("t4_product",    get_prod(0), 63);

    // Reset during WAIT drops the transaction and restarts the pointer at 0.
    s_req_valid = 4'b0010;
    step();
    s_req_valid = '0;
    run(4);
    do_reset();
    step();
    check("t5_resp_valid",   resp_valid,   0);
    check("t5_resp_id",      resp_id,      0);
    check("t5_resp_product", resp_product, 0);
    check("t5_mul_mr",       mul_mr,       0);
    check("t5_mul_md",       mul_md,       0);
    clear_logs();
    run(L + 5);
    check("t5_no_resp", resp_id_log.size(), 0);
    s_req_valid = 4'b1001;
    step();
    check("t5_grant_from_0", req_ready, 4'b0001);
    s_req_valid = '0;
    run(L + 3);

    // Edge operands 0*15 and 1*15.
    set_ops(0, 0, 15);
    set_ops(1, 1, 15);
    clear_logs();
    s_req_valid = 4'b0011;
    run(2 * (L + 3));
    s_req_valid = '0;
    check("t6_id0", get_id(0), 1);
    check("t6_p0",  get_prod(0), 15);
    check("t6_id1", get_id(1), 0);
    check("t6_p1",  get_prod(1), 0);

    // Randomized traffic with random backpressure and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      s_rst        = ($urandom_range(0, 399) != 0);
      s_req_valid  = N'($urandom);
      s_req_mr     = (W*N)'($urandom);
      s_req_md     = (W*N)'($urandom);
      s_resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
